// File: rtl/reg_scoreboard_pkg.sv
// Shared state encoding and sizing helpers for the register hazard scoreboard.
package reg_scoreboard_pkg;

  typedef logic [2:0] reg_state_t;

  localparam reg_state_t CLEAN   = 3'b001;
  localparam reg_state_t DIRTY   = 3'b010;
  localparam reg_state_t PENDING = 3'b100;

  // Address width for a register file of n entries.
  function automatic int unsigned calc_aw(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_state_cell.sv
// One register's hazard state (Clean/Dirty/PendingWrite) and its multicycle ownership tag.
module reg_state_cell
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned TAGWIDTH        = 3,
  parameter bit          HARDWIRED_CLEAN = 1'b0
) (
  input  logic                clk,
  input  logic                clk_en,
  input  logic                sync_rst,
  input  logic                issue,
  input  logic [TAGWIDTH-1:0] issue_tag,
  input  logic                wb_hit,
  input  logic                flush,
  output reg_state_t          state_o,
  output logic [TAGWIDTH-1:0] tag_o
);

  reg_state_t          state_q, state_d;
  logic [TAGWIDTH-1:0] tag_q, tag_d;

  // Flush overrides everything but keeps the tag so late writebacks read as stale.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    case (state_q)
      CLEAN: begin
        if (issue) begin
          state_d = DIRTY;
          tag_d   = issue_tag;
        end
      end
      DIRTY:   if (wb_hit) state_d = PENDING;
      PENDING: state_d = CLEAN;
      default: state_d = CLEAN;
    endcase
    if (flush) state_d = CLEAN;
    if (HARDWIRED_CLEAN) begin
      state_d = CLEAN;
      tag_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= CLEAN;
      tag_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  assign state_o = state_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register-file hazard scoreboard: issue stall, multicycle ownership tags and tagged writeback retirement.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned REGCOUNT              = 16,
  parameter int unsigned TAGWIDTH              = 3,
  parameter int unsigned WBPORTS               = 2,
  parameter bit          ZEROREGISTEREXCEPTION = 1'b1,
  localparam int unsigned AW                   = calc_aw(REGCOUNT)
) (
  input  logic                              clk,
  input  logic                              clk_en,
  input  logic                              sync_rst,
  input  logic                              InstructionValid,
  input  logic [AW-1:0]                     SrcA,
  input  logic [AW-1:0]                     SrcB,
  input  logic                              SrcAUsed,
  input  logic                              SrcBUsed,
  input  logic [AW-1:0]                     Dest,
  input  logic                              DestWrite,
  input  logic                              DestMulticycle,
  input  logic [TAGWIDTH-1:0]               IssueTag,
  input  logic                              Flush,
  input  logic [WBPORTS-1:0]                WBValid,
  input  logic [WBPORTS-1:0][AW-1:0]        WBDest,
  input  logic [WBPORTS-1:0][TAGWIDTH-1:0]  WBTag,
  output logic                              Stall,
  output logic                              Accept,
  output logic [REGCOUNT-1:0]               DirtyMask,
  output logic [REGCOUNT-1:0]               PendingMask,
  output logic [WBPORTS-1:0]                StaleWB
);

  reg_state_t          state [REGCOUNT];
  logic [TAGWIDTH-1:0] tag   [REGCOUNT];
  logic [REGCOUNT-1:0] busy;
  logic [REGCOUNT-1:0] issue_hit;
  logic [REGCOUNT-1:0] wb_hit;
  logic [WBPORTS-1:0]  shadowed;
  logic [WBPORTS-1:0]  wb_match;

  always_comb begin
    busy        = '0;
    DirtyMask   = '0;
    PendingMask = '0;
    for (int unsigned r = 0; r < REGCOUNT; r++) begin
      busy[r]        = (state[r] != CLEAN);
      DirtyMask[r]   = (state[r] == DIRTY);
      PendingMask[r] = (state[r] == PENDING);
    end
    if (ZEROREGISTEREXCEPTION) busy[0] = 1'b0;
  end

  assign Stall  = InstructionValid & ((SrcAUsed & busy[SrcA]) |
                                      (SrcBUsed & busy[SrcB]) |
                                      (DestWrite & busy[Dest]));
  assign Accept = InstructionValid & ~Stall & ~Flush & clk_en;

  always_comb begin
    issue_hit = '0;
    for (int unsigned r = 0; r < REGCOUNT; r++) begin
      issue_hit[r] = Accept & DestWrite & DestMulticycle & (Dest == AW'(r));
    end
  end

  // Lowest-index port owns a register when several ports name it in one cycle.
  always_comb begin
    shadowed = '0;
    wb_match = '0;
    wb_hit   = '0;
    StaleWB  = '0;
    for (int unsigned p = 0; p < WBPORTS; p++) begin
      for (int unsigned q = 0; q < p; q++) begin
        if (WBValid[q] && (WBDest[q] == WBDest[p])) shadowed[p] = 1'b1;
      end
      wb_match[p] = WBValid[p] & ~shadowed[p] &
                    (state[WBDest[p]] == DIRTY) & (WBTag[p] == tag[WBDest[p]]);
      StaleWB[p]  = clk_en & WBValid[p] & ~wb_match[p] &
                    ~(ZEROREGISTEREXCEPTION && (WBDest[p] == '0));
      for (int unsigned r = 0; r < REGCOUNT; r++) begin
        if (wb_match[p] && (WBDest[p] == AW'(r))) wb_hit[r] = 1'b1;
      end
    end
  end

  for (genvar r = 0; r < REGCOUNT; r++) begin : g_cell
    reg_state_cell #(
      .TAGWIDTH        (TAGWIDTH),
      .HARDWIRED_CLEAN (ZEROREGISTEREXCEPTION && (r == 0))
    ) u_cell (
      .clk       (clk),
      .clk_en    (clk_en),
      .sync_rst  (sync_rst),
      .issue     (issue_hit[r]),
      .issue_tag (IssueTag),
      .wb_hit    (wb_hit[r]),
      .flush     (Flush),
      .state_o   (state[r]),
      .tag_o     (tag[r])
    );
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register scoreboard that tracks the hazard state of every architectural register. It generalises the single-register Clean/Dirty/Pending-Write tracker to a full register file, and adds multiple writeback ports, tagged multicycle ownership and a pipeline flush. It sits between decode/issue and the register file. It produces the issue stall and per-register busy status, and absorbs writeback notifications from multicycle units (load/store, divide).

## Interface
Parameters:
- REGCOUNT, 16, number of architectural registers (power of two, ≥2); AW = clog2(REGCOUNT)
- TAGWIDTH, 3, width of the multicycle ownership tag
- WBPORTS, 2, number of multicycle writeback notification ports
- ZEROREGISTEREXCEPTION, 1, when 1 register 0 is permanently Clean and never stalls

Ports:
- clk  in  1  clock
- clk_en  in  1  global enable; all state updates are gated by it
- sync_rst  in  1  reset, synchronous, active-high; overrides clk_en
- InstructionValid  in  1  decode presents an instruction
- SrcA, SrcB  in  AW each  operand register addresses
- SrcAUsed, SrcBUsed  in  1 each  operand is actually read
- Dest  in  AW  destination register
- DestWrite  in  1  instruction writes Dest
- DestMulticycle  in  1  the write to Dest completes later through a writeback port
- IssueTag  in  TAGWIDTH  tag of a multicycle issue
- Flush  in  1  squash all in-flight multicycle ownership
- WBValid  in  WBPORTS  writeback notification valid, per port
- WBDest  in  WBPORTS×AW  writeback register, per port
- WBTag  in  WBPORTS×TAGWIDTH  writeback tag, per port
- Stall  out  1  instruction must not issue this cycle
- Accept  out  1  instruction issues this cycle
- DirtyMask  out  REGCOUNT  register is in state Dirty
- PendingMask  out  REGCOUNT  register is in state PendingWrite
- StaleWB  out  WBPORTS  pulse per port: the writeback was ignored (tag mismatch or register not Dirty)

## Operation
- Each register has a one-hot state: Clean 3'b001, Dirty 3'b010, PendingWrite 3'b100. Each register also holds a stored tag.
- Busy(r) = state(r) ≠ Clean. With ZEROREGISTEREXCEPTION=1, Busy(0) is always 0.
- Stall = InstructionValid & ((SrcAUsed & Busy(SrcA)) | (SrcBUsed & Busy(SrcB)) | (DestWrite & Busy(Dest))).
- Accept = InstructionValid & ~Stall & ~Flush & clk_en.
- State transitions, applied only when clk_en is high:
  - Clean → Dirty on Accept & DestWrite & DestMulticycle targeting r; the stored tag is loaded from IssueTag.
  - Clean stays Clean for a single-cycle write (Accept & DestWrite & ~DestMulticycle).
  - Dirty → PendingWrite on any WBValid[p] with WBDest[p]=r and WBTag[p] = stored tag.
  - A Dirty register whose writeback tag mismatches stays Dirty, and StaleWB[p] is raised.
  - PendingWrite → Clean unconditionally on the next enabled cycle; the register-file commit takes exactly one cycle.
  - A writeback to a Clean or PendingWrite register is ignored, and StaleWB[p] is raised.
  - Flush sends every Dirty and PendingWrite register to Clean. Stored tags are kept, so that later stale writebacks can be detected.
- Register 0 with ZEROREGISTEREXCEPTION=1: issues and writebacks to it are accepted but leave it Clean. Writebacks to it never raise StaleWB.
- Simultaneous events:
  - Flush beats issue and writeback in the same cycle; Accept is forced low.
  - If two ports hit the same register in one cycle, the lowest port index is used. The other ports raise StaleWB. This case is illegal, and the bench flags it.
  - A writeback and an issue that reads the same register in the same cycle: the register is still Dirty, so Stall=1.
- Unknown state encodings (never reachable) recover to Clean.

## Timing
- Stall, Accept, DirtyMask and PendingMask are combinational from current state and inputs. There is no internal issue latency.
- A multicycle issue accepted in cycle t makes the register Dirty from t+1.
- A matching writeback in cycle t gives PendingWrite at t+1 and Clean at t+2. A reader waiting on the register issues at t+2 at the earliest.
- StaleWB is combinational in cycle t and valid only when clk_en=1.
- Reset: all states Clean, all tags 0, DirtyMask=0, PendingMask=0, Stall=0 when InstructionValid=0, StaleWB=0.
- Reset mid-operation discards all ownership. Writebacks arriving after reset are stale.

## Structure
- Package reg_scoreboard_pkg holds:
  - the state constants (CLEAN, DIRTY, PENDING)
  - a state typedef for the 3-bit one-hot state
  - a function computing AW
- Sub-module reg_state_cell holds one register's state and tag. Its inputs are a decoded issue strobe, a matched-writeback strobe, and Flush.
- It is instantiated REGCOUNT times through a generate loop, with register 0 specialised by ZEROREGISTEREXCEPTION.
- Writeback decode and tag compare live in the top level.

## Test plan
- Reset, then issue multicycle Dest=5 tag=3 → DirtyMask[5]=1 at t+1. A following reader of r5 sees Stall=1.
- WB port 1 Dest=5 tag=3 → PendingMask[5]=1 next cycle, then Clean. The stalled reader Accepts 2 cycles after the WB.
- Issue Dest=5 tag=3, Flush, then issue Dest=5 tag=4, then WB Dest=5 tag=3 → StaleWB[p]=1 and r5 stays Dirty. A later WB with tag=4 clears it.
- Issue multicycle to r0 with ZEROREGISTEREXCEPTION=1 → Stall=0 and DirtyMask[0]=0 always. With the parameter set to 0, r0 behaves like any other register.
- Both ports write back Dest=7 tag=2 in the same cycle → port 0 is used, StaleWB=2'b10, and r7 goes to PendingWrite.
- Hold clk_en=0 during a matching WB → no state change. Assert sync_rst with clk_en=0 → all registers go Clean.
